// File: rtl/pwm_multi_ch.sv
// Multi-channel active-low PWM: one shared period counter, per-channel duty shadowed until wrap.
// Optional PWM_STAGGER_EN phase-offsets each channel by i*(CNT_NUM/CH_NUM) counts.
module pwm_multi_ch #(
  parameter int CNT_NUM   = 8,
  parameter int CNT_WIDTH = $clog2(CNT_NUM + 1),
  parameter int CH_NUM    = 4,
  parameter int CH_WIDTH  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_en,
  input  logic [CH_WIDTH-1:0]  wr_ch,
  input  logic [CNT_WIDTH-1:0] wr_duty,
  output logic [CH_NUM-1:0]    out,
  output logic                 period_start
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] DUTY_MAX = CNT_WIDTH'(CNT_NUM);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] shadow_q [CH_NUM];
  logic [CNT_WIDTH-1:0] shadow_d [CH_NUM];
  logic [CNT_WIDTH-1:0] active_q [CH_NUM];
  logic [CNT_WIDTH-1:0] active_d [CH_NUM];
  logic [CH_NUM-1:0]    out_q, out_d;
  logic                 period_start_q, period_start_d;

  logic                 wrap;
  logic [CNT_WIDTH-1:0] duty_clamped;
  logic [CNT_WIDTH-1:0] idx [CH_NUM];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_idx
`ifdef PWM_STAGGER_EN
    localparam int IDX_W = CNT_WIDTH + 1;
    localparam int STAGGER_STEP = CNT_NUM / CH_NUM;
    logic [CNT_WIDTH:0] sum;
    // Offset is always below CNT_NUM, so a single conditional subtract is the modulo.
    assign sum    = {1'b0, cnt_q} + IDX_W'(g * STAGGER_STEP);
    assign idx[g] = (sum >= IDX_W'(CNT_NUM)) ? CNT_WIDTH'(sum - IDX_W'(CNT_NUM))
                                             : sum[CNT_WIDTH-1:0];
`else
    assign idx[g] = cnt_q;
`endif
  end

  always_comb begin
    wrap           = en && (cnt_q == CNT_LAST);
    duty_clamped   = (wr_duty > DUTY_MAX) ? DUTY_MAX : wr_duty;
    cnt_d          = cnt_q;
    out_d          = '1;
    period_start_d = en && (cnt_q == '0);

    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    for (int i = 0; i < CH_NUM; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (wr_en && (int'(wr_ch) == i)) begin
        shadow_d[i] = duty_clamped;
      end
      // Taking shadow_d gives the same-cycle write bypass into active.
      if (wrap) begin
        active_d[i] = shadow_d[i];
      end
      if (en) begin
        out_d[i] = (idx[i] < active_q[i]) ? 1'b0 : 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      out_q          <= '1;
      period_start_q <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
      for (int i = 0; i < CH_NUM; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule
